// File: rtl/toa_pattern_gen.sv
// -----------------------------------------------------------------------------
// toa_pattern_gen
//   Emulates the raw capture of a time-of-arrival converter: a 63-tap delay
//   line (thermometer code that fills with ones and then drains) plus two taps
//   of a 3-bit ripple counter.  A sweep starts at codeStart and emits numCodes
//   words, advancing the fine code by step per accepted word.  An optional
//   single-bit bubble is injected into the delay-line image.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   start              sweep request, sampled only while idle
//   codeStart          first code {coarse[9:7], fine[6:0]}
//   numCodes           number of words in the sweep
//   step               fine-code increment per word
//   bubbleEn/bubblePos bubble injection control (pos 63 = none)
//   outReady           downstream accepts the current word
//   outValid           word outputs valid
//   A                  delay-line DFF image
//   counterA/counterB  ripple counter positive/negative-edge taps
//   expCode            code represented by the word
//   busy, done         sweep in progress / one-cycle end-of-sweep pulse
//   cfgError           sticky configuration error
// -----------------------------------------------------------------------------
module toa_pattern_gen (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [9:0]  codeStart,
    input  logic [9:0]  numCodes,
    input  logic [6:0]  step,
    input  logic        bubbleEn,
    input  logic [5:0]  bubblePos,
    input  logic        outReady,
    output logic        outValid,
    output logic [62:0] A,
    output logic [2:0]  counterA,
    output logic [2:0]  counterB,
    output logic [9:0]  expCode,
    output logic        busy,
    output logic        done,
    output logic        cfgError
);

    localparam logic [6:0] FINE_MAX = 7'd125;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      r_state;
    logic [9:0]  r_left;      // words still to be accepted, current one included
    logic [6:0]  r_step;
    logic        r_bub_en;
    logic [5:0]  r_bub_pos;

    logic [7:0]  w_sum;
    logic [6:0]  w_next_fine;
    logic [2:0]  w_next_coarse;

    // Delay-line image: fills with ones for fine 0..62, then drains from the
    // bottom for fine 63..125.  The bubble is applied after the ideal pattern.
    function automatic logic [62:0] make_a(input logic [6:0] fine,
                                           input logic       en,
                                           input logic [5:0] pos);
        logic [62:0] a;
        for (int i = 0; i < 63; i++) begin
            if (fine <= 7'd62) a[i] = (7'(i) < fine);
            else               a[i] = (7'(i) >= (fine - 7'd63));
        end
        if (en && (pos <= 6'd62)) a[pos] = ~a[pos];
        return a;
    endfunction

    // The positive-edge tap has already counted the extra period once the
    // delay line has started draining.
    function automatic logic [2:0] tap_a(input logic [6:0] fine,
                                         input logic [2:0] coarse);
        return (fine >= 7'd63) ? coarse + 3'd1 : coarse;
    endfunction

    // 8-bit sum: fine (<=125) + step (<=127) never overflows.
    assign w_sum = {1'b0, expCode[6:0]} + {1'b0, r_step};

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; a missing
        // branch in always_comb would otherwise infer a latch.
        w_next_fine   = w_sum[6:0];
        w_next_coarse = expCode[9:7];
        if (w_sum > {1'b0, FINE_MAX}) begin
            w_next_fine   = 7'(w_sum - 8'd126);
            w_next_coarse = expCode[9:7] + 3'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_left    <= '0;
            r_step    <= '0;
            r_bub_en  <= 1'b0;
            r_bub_pos <= '0;
            outValid  <= 1'b0;
            A         <= '0;
            counterA  <= '0;
            counterB  <= '0;
            expCode   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfgError  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_step    <= step;
                        r_bub_en  <= bubbleEn;
                        r_bub_pos <= bubblePos;
                        r_left    <= numCodes;
                        busy      <= 1'b1;
                        cfgError  <= 1'b0;
                        if ((step == 7'd0) || (codeStart[6:0] > FINE_MAX)) begin
                            cfgError <= 1'b1;
                            done     <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (numCodes == 10'd0) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            // First word is built straight from the inputs so it
                            // is valid the cycle after start is sampled.
                            outValid <= 1'b1;
                            expCode  <= codeStart;
                            A        <= make_a(codeStart[6:0], bubbleEn, bubblePos);
                            counterA <= tap_a(codeStart[6:0], codeStart[9:7]);
                            counterB <= codeStart[9:7];
                            r_state  <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    if (outReady) begin
                        if (r_left == 10'd1) begin
                            outValid <= 1'b0;
                            done     <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_left   <= r_left - 10'd1;
                            expCode  <= {w_next_coarse, w_next_fine};
                            A        <= make_a(w_next_fine, r_bub_en, r_bub_pos);
                            counterA <= tap_a(w_next_fine, w_next_coarse);
                            counterB <= w_next_coarse;
                        end
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_toa_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_toa_pattern_gen
//   Table of sweep configurations; each entry fills a scoreboard queue with the
//   words an independent model predicts, then the sweep is run with optional
//   back-pressure and a start pulse while busy.  Hand-written sequences cover
//   reset state and reset asserted mid-sweep.
// -----------------------------------------------------------------------------
module tb_toa_pattern_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [9:0]  codeStart;
    logic [9:0]  numCodes;
    logic [6:0]  step;
    logic        bubbleEn;
    logic [5:0]  bubblePos;
    logic        outReady;
    logic        outValid;
    logic [62:0] A;
    logic [2:0]  counterA;
    logic [2:0]  counterB;
    logic [9:0]  expCode;
    logic        busy;
    logic        done;
    logic        cfgError;

    always #5 clk = ~clk;

    toa_pattern_gen dut (
        .clk(clk), .rstn(rstn), .start(start), .codeStart(codeStart),
        .numCodes(numCodes), .step(step), .bubbleEn(bubbleEn),
        .bubblePos(bubblePos), .outReady(outReady), .outValid(outValid),
        .A(A), .counterA(counterA), .counterB(counterB), .expCode(expCode),
        .busy(busy), .done(done), .cfgError(cfgError)
    );

    typedef struct {
        logic [9:0]  cs;
        logic [9:0]  nc;
        logic [6:0]  st;
        logic        be;
        logic [5:0]  bp;
        int          stall_at;    // accept index at which to hold outReady low
        int          stall_len;
        bit          busy_start;  // pulse start mid-sweep with junk config
        bit          exp_err;
        bit          chk_first;
        logic [62:0] first_a;
        bit          chk_last;
        logic [9:0]  last_code;
    } vec_t;

    typedef struct {
        logic [62:0] a;
        logic [2:0]  ca;
        logic [2:0]  cb;
        logic [9:0]  code;
    } word_t;

    word_t q[$];
    vec_t  vecs[10];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [9:0] cs, input logic [9:0] nc,
                                input logic [6:0] st, input logic be,
                                input logic [5:0] bp, input int stall_at,
                                input int stall_len, input bit busy_start,
                                input bit exp_err, input bit chk_first,
                                input logic [62:0] first_a, input bit chk_last,
                                input logic [9:0] last_code);
        vec_t v;
        v.cs = cs; v.nc = nc; v.st = st; v.be = be; v.bp = bp;
        v.stall_at = stall_at; v.stall_len = stall_len;
        v.busy_start = busy_start; v.exp_err = exp_err;
        v.chk_first = chk_first; v.first_a = first_a;
        v.chk_last = chk_last; v.last_code = last_code;
        return v;
    endfunction

    // Mask-based model of the delay-line image.
    function automatic logic [62:0] model_a(input int fine, input logic be, input logic [5:0] bp);
        logic [63:0] m;
        if (fine <= 62) m = (64'd1 << fine) - 64'd1;
        else            m = ~((64'd1 << (fine - 63)) - 64'd1);
        if (be && bp != 6'd63) m[bp] = ~m[bp];
        return m[62:0];
    endfunction

    task automatic run(input vec_t v);
        word_t      w;
        int         fine, n, acc, stall_cnt, done_cnt, cyc;
        logic [2:0] coarse;
        logic [9:0] last_seen;
        bit         first_done;

        q.delete();
        n = (v.st != 0 && v.cs[6:0] <= 7'd125) ? int'(v.nc) : 0;
        fine   = int'(v.cs[6:0]);
        coarse = v.cs[9:7];
        for (int k = 0; k < n; k++) begin
            w.a    = model_a(fine, v.be, v.bp);
            w.cb   = coarse;
            w.ca   = (fine >= 63) ? coarse + 3'd1 : coarse;
            w.code = {coarse, 7'(fine)};
            q.push_back(w);
            fine = fine + int'(v.st);
            if (fine > 125) begin
                fine   = fine - 126;
                coarse = coarse + 3'd1;
            end
        end

        @(negedge clk);
        codeStart = v.cs; numCodes = v.nc; step = v.st;
        bubbleEn = v.be; bubblePos = v.bp;
        start = 1'b1; outReady = 1'b1;
        @(negedge clk);
        // Scramble configuration to show it was captured at acceptance.
        start = 1'b0; codeStart = ~v.cs; numCodes = 10'd1; step = 7'd0;
        bubbleEn = ~v.be; bubblePos = 6'd0;
        check("latency_valid", {63'd0, outValid}, {63'd0, (n > 0)});
        check("busy_after_start", {63'd0, busy}, 64'd1);

        acc = 0; stall_cnt = 0; done_cnt = 0; cyc = 0;
        first_done = 1'b0; last_seen = '0;
        while (busy && cyc < 400) begin
            start = (v.busy_start && cyc == 2);
            if (q.size() > 0) check("valid_hold", {63'd0, outValid}, 64'd1);
            if (outValid) begin
                if (q.size() == 0) begin
                    check("extra_word", {63'd0, outValid}, 64'd0);
                    outReady = 1'b1;
                end else begin
                    check("A",        {1'b0, A},          {1'b0, q[0].a});
                    check("counterA", {61'd0, counterA},  {61'd0, q[0].ca});
                    check("counterB", {61'd0, counterB},  {61'd0, q[0].cb});
                    check("expCode",  {54'd0, expCode},   {54'd0, q[0].code});
                    if (v.chk_first && !first_done)
                        check("first_A", {1'b0, A}, {1'b0, v.first_a});
                    first_done = 1'b1;
                    last_seen  = expCode;
                    if (acc == v.stall_at && stall_cnt < v.stall_len) begin
                        outReady = 1'b0;
                        stall_cnt++;
                    end else begin
                        outReady = 1'b1;
                        void'(q.pop_front());
                        acc++;
                    end
                end
            end else begin
                outReady = 1'($urandom_range(0, 1));
            end
            if (done) begin
                done_cnt++;
                check("done_busy",    {63'd0, busy},     64'd1);
                check("done_novalid", {63'd0, outValid}, 64'd0);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("sweep_timeout", {63'd0, (cyc < 400)}, 64'd1);
        check("words_left", 64'(q.size()), 64'd0);
        check("done_count", 64'(done_cnt), 64'd1);
        check("cfgError", {63'd0, cfgError}, {63'd0, v.exp_err});
        check("idle_valid", {63'd0, outValid}, 64'd0);
        if (v.chk_last) check("last_code", {54'd0, last_seen}, {54'd0, v.last_code});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_A"},        {1'b0, A},         64'd0);
        check({tag, "_counters"}, {58'd0, counterA, counterB}, 64'd0);
        check({tag, "_expCode"},  {54'd0, expCode},  64'd0);
        check({tag, "_flags"},    {60'd0, outValid, busy, done, cfgError}, 64'd0);
    endtask

    initial begin
        int done_seen;

        //            cs                nc     st      be    bp    stall  len busy err first  first_a                     last  last_code
        vecs[0] = mk(10'h000,          10'd3, 7'd1,   1'b0, 6'd63, -1, 0, 1'b0, 1'b0, 1'b1, 63'h0,                     1'b1, 10'h002);
        vecs[1] = mk({3'd2, 7'd62},    10'd2, 7'd1,   1'b0, 6'd63, -1, 0, 1'b0, 1'b0, 1'b1, 63'h3FFF_FFFF_FFFF_FFFF,   1'b1, 10'h13F);
        vecs[2] = mk({3'd7, 7'd120},   10'd2, 7'd10,  1'b0, 6'd63, -1, 0, 1'b0, 1'b0, 1'b0, 63'h0,                     1'b1, 10'h004);
        vecs[3] = mk({3'd1, 7'd10},    10'd4, 7'd1,   1'b1, 6'd5,   1, 5, 1'b0, 1'b0, 1'b1, 63'h3DF,                   1'b0, 10'h000);
        vecs[4] = mk({3'd1, 7'd10},    10'd2, 7'd1,   1'b1, 6'd63, -1, 0, 1'b0, 1'b0, 1'b1, 63'h3FF,                   1'b0, 10'h000);
        vecs[5] = mk(10'h000,          10'd3, 7'd0,   1'b0, 6'd63, -1, 0, 1'b0, 1'b1, 1'b0, 63'h0,                     1'b0, 10'h000);
        vecs[6] = mk({3'd0, 7'd100},   10'd5, 7'd127, 1'b1, 6'd63,  2, 3, 1'b0, 1'b0, 1'b0, 63'h0,                     1'b0, 10'h000);
        vecs[7] = mk({3'd3, 7'd126},   10'd3, 7'd1,   1'b0, 6'd63, -1, 0, 1'b0, 1'b1, 1'b0, 63'h0,                     1'b0, 10'h000);
        vecs[8] = mk({3'd4, 7'd5},     10'd0, 7'd1,   1'b0, 6'd63, -1, 0, 1'b0, 1'b0, 1'b0, 63'h0,                     1'b0, 10'h000);
        vecs[9] = mk({3'd2, 7'd70},    10'd3, 7'd5,   1'b1, 6'd62, -1, 0, 1'b1, 1'b0, 1'b1, 63'h3FFF_FFFF_FFFF_FF80,   1'b1, 10'h150);

        rstn = 1'b0; start = 1'b0; codeStart = '0; numCodes = '0; step = '0;
        bubbleEn = 1'b0; bubblePos = '0; outReady = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) run(vecs[i]);

        // Leave cfgError set, then abort a legal sweep with reset mid-flight.
        run(vecs[5]);
        @(negedge clk);
        codeStart = 10'h000; numCodes = 10'd10; step = 7'd3;
        bubbleEn = 1'b0; bubblePos = 6'd63; start = 1'b1; outReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_reset_valid", {63'd0, outValid}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rstn = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || busy || outValid) done_seen++;
        end
        check("post_reset_quiet", 64'(done_seen), 64'd0);

        run(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/toa_pattern_gen.md
TOA_PATTERN_GEN -- requirements
Module: toa_pattern_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be as listed in REQ-002..REQ-019.
REQ-002 clk  input  1  block clock; all state updates on rising edge.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 start  input  1  single-cycle sweep request; sampled only in IDLE.
REQ-005 codeStart  input  10  first code: [9:7] coarse, [6:0] fine.
REQ-006 numCodes  input  10  number of codes to emit.
REQ-007 step  input  7  fine-code increment per emitted code.
REQ-008 bubbleEn  input  1  enable single-bit bubble injection.
REQ-009 bubblePos  input  6  tap to invert; 63 = no injection.
REQ-010 outReady  input  1  downstream accepts the current word.
REQ-011 outValid  output  1  A/counterA/counterB/expCode are valid.
REQ-012 A  output  63  emulated delay-line DFF states.
REQ-013 counterA  output  3  emulated ripple counter, positive-edge tap.
REQ-014 counterB  output  3  emulated ripple counter, negative-edge tap.
REQ-015 expCode  output  10  code the word represents, {coarse, fine}.
REQ-016 busy  output  1  high from start acceptance until done.
REQ-017 done  output  1  one-cycle pulse at end of sweep.
REQ-018 cfgError  output  1  sticky configuration error, cleared by next accepted start.
REQ-019 All inputs except rstn SHALL be synchronous to clk; configuration inputs SHALL be captured on start acceptance and ignored afterwards.

Function
REQ-020 Legal fine codes SHALL be 0..125; coarse SHALL be 0..7, wrapping modulo 8.
REQ-021 For fine f <= 62: A[i] = 1 for i < f, else 0 (f = 0 gives all zeros).
REQ-022 For fine f >= 63: A[i] = 0 for i < f-63, else 1 (f = 63 gives all ones).
REQ-023 For f <= 62: counterA = counterB = coarse; for f >= 63: counterA = (coarse+1) mod 8, counterB = coarse.
REQ-024 When bubbleEn = 1 and bubblePos <= 62, bit A[bubblePos] SHALL be inverted after REQ-021/022; expCode SHALL be unaffected.
REQ-025 The FSM SHALL have states IDLE, RUN and DONE.
REQ-026 IDLE: on start = 1, capture the configuration and assert busy the next cycle. If step = 0 or codeStart[6:0] > 125, set cfgError and go to DONE. Else if numCodes = 0, go to DONE. Else go to RUN.
REQ-027 RUN: outValid = 1 with registered outputs; outputs SHALL hold stable while outValid && !outReady.
REQ-028 On an accepted handshake (outValid && outReady), the next code SHALL be presented on the following cycle with outValid kept high; there SHALL be no idle cycle between accepted words.
REQ-029 Next-code arithmetic: fine' = fine + step; if fine' > 125 then fine' -= 126 and coarse += 1 mod 8; the computation SHALL use 8-bit width, with no overflow for step <= 127.
REQ-030 After the numCodes-th acceptance, outValid SHALL drop on the next cycle and the FSM SHALL enter DONE.
REQ-031 DONE SHALL last exactly one cycle with done = 1 and busy = 1, then return to IDLE with busy = 0.
REQ-032 start while busy SHALL be ignored, with no effect on the sweep or on cfgError.
REQ-033 Latency: the first word SHALL be valid 1 cycle after start is sampled.
REQ-034 outReady while outValid = 0 SHALL have no effect.

Reset
REQ-035 On rstn low, state SHALL be IDLE and every output SHALL be 0 (A = 0, counterA = counterB = 0, expCode = 0, outValid = busy = done = cfgError = 0), immediately and independent of clk.
REQ-036 Reset asserted mid-sweep SHALL abort the sweep without a done pulse; after release, the block SHALL wait for a new start.

Verification
REQ-037 Scenario: codeStart = 0x000, numCodes = 3, step = 1, outReady = 1 -> fine 0, 1, 2 on consecutive cycles; A = 0, 0x1, 0x3; counters 0/0; done pulses one cycle after the third accept.
REQ-038 Scenario: codeStart = {3'd2, 7'd62}, step = 1, numCodes = 2 -> word 1: A = 63'h3FFF_FFFF_FFFF_FFFF... with bits 0..61 set, counters 2/2; word 2: f = 63, A all ones, counterA = 3, counterB = 2.
REQ-039 Scenario: codeStart = {3'd7, 7'd120}, step = 10, numCodes = 2 -> second expCode = {3'd0, 7'd4}, i.e. both fine and coarse wrap.
REQ-040 Scenario: outReady held low for 5 cycles during RUN -> outputs stable, outValid high, no code skipped after outReady rises.
REQ-041 Scenario: step = 0 -> cfgError = 1, outValid never asserted, done pulses once; a subsequent legal start clears cfgError.
REQ-042 Scenario: bubbleEn = 1, bubblePos = 5, f = 10 -> A = 0x3DF; with bubblePos = 63, A = 0x3FF; reset asserted mid-sweep -> all outputs 0 and no done pulse.
